// File: rtl/adc_capture_sequencer.sv
// adc_capture_sequencer: free-running ADC strobe sequencer with edge trigger and one-frame capture into sample RAM.
// Optional AUTO_TRIG_EN: force a trigger after AUTO_TO untriggered samples (free-run display).
module adc_capture_sequencer #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 640,
    parameter int ADDR_W      = 10,
    parameter int CONVST_LOW  = 4,
    parameter int CONV_CYCLES = 150,
    parameter int RD_LOW      = 5,
    parameter int AUTO_TO     = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       sample_div,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_rising,
    input  logic              arm,
    input  logic [DATA_W-1:0] db,
    output logic              convstb,
    output logic              csb,
    output logic              rdb,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              armed,
    output logic              capturing,
    output logic              done
);
    localparam logic [1:0] S_CONV = 2'd0, S_WAIT = 2'd1, S_READ = 2'd2, S_HOLD = 2'd3;
    localparam logic [1:0] C_IDLE = 2'd0, C_ARMED = 2'd1, C_CAPT = 2'd2, C_DONE = 2'd3;
    localparam logic [15:0] SEQ    = 16'(CONVST_LOW + CONV_CYCLES + RD_LOW);
    localparam logic [15:0] END_CV = 16'(CONVST_LOW - 1);
    localparam logic [15:0] END_WT = 16'(CONVST_LOW + CONV_CYCLES - 1);
    localparam logic [15:0] END_RD = SEQ - 16'd1;
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);

    logic [1:0]        s_q, s_d, c_q, c_d;
    logic [15:0]       per_q, per_d, p_q, p_d, p_req;
    logic              wrap, convstb_q, csb_q, rdb_q, rl_q, vld_q;
    logic [DATA_W-1:0] smp_q, prev_q, wr_data_q;
    logic              pv_q, pv_d, edge_hit, trig, last, wr_d, wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

    // Phases are decoded from the period counter so convstb falls exactly P cycles apart.
    always_comb begin
        p_req = sample_div > SEQ ? sample_div : SEQ;
        wrap  = per_q == p_q - 16'd1;
        per_d = wrap ? 16'd0 : per_q + 16'd1;
        p_d   = wrap ? p_req : p_q;
        s_d   = s_q;
        case (s_q)
            S_CONV:  s_d = per_q == END_CV ? S_WAIT : S_CONV;
            S_WAIT:  s_d = per_q == END_WT ? S_READ : S_WAIT;
            S_READ:  s_d = per_q == END_RD ? (wrap ? S_CONV : S_HOLD) : S_READ;
            default: s_d = wrap ? S_CONV : S_HOLD;
        endcase
    end

    // Strobes are registered from the state, so every pin lags the state by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q       <= S_CONV;
            per_q     <= 16'd0;
            p_q       <= p_req;
            convstb_q <= 1'b1;
            csb_q     <= 1'b1;
            rdb_q     <= 1'b1;
            rl_q      <= 1'b0;
            vld_q     <= 1'b0;
            smp_q     <= '0;
        end else begin
            s_q       <= s_d;
            per_q     <= per_d;
            p_q       <= p_d;
            convstb_q <= s_q != S_CONV;
            csb_q     <= s_q != S_READ;
            rdb_q     <= s_q != S_READ;
            rl_q      <= s_q == S_READ && per_q == END_RD;
            vld_q     <= rl_q;
            if (rl_q) smp_q <= db;
        end
    end

    assign edge_hit = vld_q && pv_q && (trig_rising ? (prev_q < trig_level && smp_q >= trig_level)
                                                    : (prev_q > trig_level && smp_q <= trig_level));

`ifdef AUTO_TRIG_EN
    localparam int ACNT_W = $clog2(AUTO_TO + 2);
    logic [ACNT_W-1:0] acnt_q;
    always_ff @(posedge clk) begin
        if (rst || (arm && c_q != C_CAPT)) acnt_q <= '0;
        else if (vld_q && c_q == C_ARMED) acnt_q <= acnt_q + ACNT_W'(1);
    end
    assign trig = edge_hit || (vld_q && acnt_q >= ACNT_W'(AUTO_TO));
`else
    assign trig = edge_hit;
`endif

    always_comb begin
        last = wr_en_q && wr_addr_q == LAST_A;
        c_d  = c_q;
        case (c_q)
            C_IDLE:  c_d = arm ? C_ARMED : C_IDLE;
            C_ARMED: c_d = !arm && trig ? C_CAPT : C_ARMED;
            C_CAPT:  c_d = last ? C_DONE : C_CAPT;
            default: c_d = arm ? C_ARMED : C_DONE;
        endcase
        wr_d      = vld_q && ((c_q == C_ARMED && c_d == C_CAPT) || c_q == C_CAPT);
        wr_addr_d = last ? '0 : (wr_d && c_q == C_CAPT) ? wr_addr_q + ADDR_W'(1) : wr_addr_q;
        pv_d      = (arm && c_q != C_CAPT) ? 1'b0 : (vld_q && c_q == C_ARMED) ? 1'b1 : pv_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q       <= C_IDLE;
            pv_q      <= 1'b0;
            prev_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            c_q       <= c_d;
            pv_q      <= pv_d;
            wr_en_q   <= wr_d;
            wr_addr_q <= wr_addr_d;
            if (vld_q) prev_q <= smp_q;
            if (wr_d) wr_data_q <= smp_q;
        end
    end

    assign convstb   = convstb_q;
    assign csb       = csb_q;
    assign rdb       = rdb_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign armed     = c_q == C_ARMED;
    assign capturing = c_q == C_CAPT;
    assign done      = c_q == C_DONE;
endmodule
